logc_expand: RTL and testbench

- Inverse of the log-compression front end: converts a fixed-point log2-domain code back to a linear magnitude.
- Computes 2^(code) using a 33-entry mantissa ROM with linear interpolation, followed by a barrel shift, rounding and saturation.
- Sits after log-domain processing (gain, compounding, filtering) and feeds linear-domain consumers.
- Three-stage pipeline with a valid/ready stream on both sides; sustains 1 sample/cycle.

---
 rtl/logc_pkg.sv | 16 +
 rtl/logc_exp2_lut.sv | 14 +
 rtl/logc_expand.sv | 85 ++++++++
 tb/tb_logc_expand.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/logc_pkg.sv
// logc_pkg: shared constants and the 2^(k/32) mantissa ROM for the log-to-linear expander
package logc_pkg;
  localparam int MANT_W = 17;
  localparam int MANT_FRAC = MANT_W - 2;
  localparam int IDX_W = 5;
  localparam int INTERP_W = 3;
  localparam int ROM_N = 33;
  // round(2^(k/32) * 32768), Q2.15
  localparam logic [MANT_W-1:0] EXP2_ROM [ROM_N] = '{
    17'd32768, 17'd33486, 17'd34219, 17'd34968, 17'd35734, 17'd36516, 17'd37316, 17'd38133,
    17'd38968, 17'd39821, 17'd40693, 17'd41584, 17'd42495, 17'd43425, 17'd44376, 17'd45348,
    17'd46341, 17'd47356, 17'd48393, 17'd49452, 17'd50535, 17'd51642, 17'd52773, 17'd53928,
    17'd55109, 17'd56316, 17'd57549, 17'd58809, 17'd60097, 17'd61413, 17'd62757, 17'd64132,
    17'd65536
  };
endpackage

// File: rtl/logc_exp2_lut.sv
// logc_exp2_lut: combinational mantissa ROM returning the segment endpoints L[k] and L[k+1]
//   k_i    : segment index
//   base_o : L[k]
//   next_o : L[k+1]
module logc_exp2_lut
  import logc_pkg::*;
(
  input  logic [IDX_W-1:0]  k_i,
  output logic [MANT_W-1:0] base_o,
  output logic [MANT_W-1:0] next_o
);
  assign base_o = EXP2_ROM[{1'b0, k_i}];
  assign next_o = EXP2_ROM[{1'b0, k_i} + 6'd1];
endmodule

// File: rtl/logc_expand.sv
// logc_expand: 3-stage log2-code to linear converter (ROM lookup, interpolation, shift/round/saturate)
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : input handshake, data_in = log code Q(DATA_WIDTH-FRAC_W).FRAC_W
//   out_valid/out_ready   : output handshake, data_out = round(2^code) saturated, sat = saturated flag
module logc_expand
  import logc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_W = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  sat
);
  localparam int EW = DATA_WIDTH - FRAC_W;
  localparam int FX = IDX_W + INTERP_W;
  localparam int PW = MANT_W + INTERP_W;
  localparam int UW = MANT_W + OUT_WIDTH;
  logic adv;
  logic [FX-1:0] fx;
  logic [MANT_W-1:0] base_d, next_d, m_d;
  logic [PW-1:0] prod;
  logic [UW-1:0] up;
  logic [MANT_W:0] dn;
  logic [OUT_WIDTH-1:0] data_d;
  logic sat_d;
  logic v1_q, v2_q, out_valid_q, sat_q;
  logic [MANT_W-1:0] base_q, next_q, m_q;
  logic [INTERP_W-1:0] lo_q;
  logic [EW-1:0] e1_q, e2_q;
  logic [OUT_WIDTH-1:0] data_q;
  assign adv = !out_valid_q || out_ready;
  assign in_ready = adv;
  // top FX fraction bits, zero-padded when FRAC_W < FX, extra low bits truncated
  assign fx = FX'({data_in[FRAC_W-1:0], {FX{1'b0}}} >> FRAC_W);
  logc_exp2_lut u_lut (
    .k_i   (fx[FX-1 -: IDX_W]),
    .base_o(base_d),
    .next_o(next_d)
  );
  assign prod = PW'(next_q - base_q) * PW'(lo_q);
  assign m_d = base_q + MANT_W'(prod >> INTERP_W);
  assign up = UW'(m_q) << (e2_q - EW'(MANT_FRAC));
  // round-half-up when the mantissa is shifted down
  assign dn = ((MANT_W+1)'(m_q) + ((MANT_W+1)'(1) << (EW'(MANT_FRAC - 1) - e2_q))) >> (EW'(MANT_FRAC) - e2_q);
  assign sat_d = e2_q >= EW'(OUT_WIDTH) || (e2_q >= EW'(MANT_FRAC) && |up[UW-1:OUT_WIDTH]);
  assign data_d = sat_d ? '1 : e2_q >= EW'(MANT_FRAC) ? up[OUT_WIDTH-1:0] : OUT_WIDTH'(dn);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      base_q <= '0;
      next_q <= '0;
      lo_q <= '0;
      e1_q <= '0;
      v2_q <= 1'b0;
      m_q <= '0;
      e2_q <= '0;
      out_valid_q <= 1'b0;
      data_q <= '0;
      sat_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      base_q <= base_d;
      next_q <= next_d;
      lo_q <= fx[INTERP_W-1:0];
      e1_q <= data_in[DATA_WIDTH-1:FRAC_W];
      v2_q <= v1_q;
      m_q <= m_d;
      e2_q <= e1_q;
      out_valid_q <= v2_q;
      data_q <= data_d;
      sat_q <= sat_d;
    end
  end
  assign out_valid = out_valid_q;
  assign data_out = data_q;
  assign sat = sat_q;
endmodule

// File: tb/tb_logc_expand.sv
// tb_logc_expand: directed and random checks of logc_expand against a scoreboard model
module tb_logc_expand;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [15:0] data_in = '0;
  logic in_ready, out_valid, sat;
  logic [15:0] data_out;
  int tests = 0;
  int fails = 0;
  int nout = 0;
  int rom [33];
  logic [16:0] sb [$];

  logc_expand dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  // expected {sat, data_out} for a code, built from the real-valued exponential
  function automatic logic [16:0] model(input logic [15:0] c);
    int e, k, lo, m;
    longint v;
    e = int'(c[15:8]);
    k = int'(c[7:3]);
    lo = int'(c[2:0]);
    m = rom[k] + ((rom[k+1] - rom[k]) * lo) / 8;
    if (e >= 16) return {1'b1, 16'hFFFF};
    if (e >= 15) begin
      v = longint'(m) << (e - 15);
      return (v >= 65536) ? {1'b1, 16'hFFFF} : {1'b0, v[15:0]};
    end
    return {1'b0, 16'((m + (1 << (14 - e))) >> (15 - e))};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] c);
    data_in = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: push at input transfer, pop and compare at output transfer
  always @(negedge clk) begin : mon
    logic [16:0] x;
    if (reset_n) begin
      if (in_valid && in_ready) sb.push_back(model(data_in));
      if (out_valid && out_ready) begin
        nout++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_extra: got %0h expected none", {sat, data_out});
        end else begin
          x = sb.pop_front();
          tests++;
          assert ({sat, data_out} === x) else begin
            fails++;
            $error("FAIL sb_data: got %0h expected %0h", {sat, data_out}, x);
          end
        end
      end
    end
  end

  initial begin
    int acc, n0;
    bit sent;
    for (int k = 0; k < 33; k++) rom[k] = $rtoi($pow(2.0, real'(k) / 32.0) * 32768.0 + 0.5);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_sat", 32'(sat), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    // code 0: accepted in cycle 0, out_valid in cycle 3
    drive(16'h0000);
    in_valid = 1'b0;
    check("lat_c1", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_c2", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_c3", 32'(out_valid), 1);
    check("code0_data", 32'(data_out), 1);
    check("code0_sat", 32'(sat), 0);
    @(posedge clk); #1;
    // back-to-back stream
    drive(16'h0400);
    drive(16'h0A80);
    drive(16'h0FFF);
    in_valid = 1'b0;
    check("str0_valid", 32'(out_valid), 1);
    check("str0_data", 32'(data_out), 16);
    @(posedge clk); #1;
    check("str1_valid", 32'(out_valid), 1);
    check("str1_data", 32'(data_out), 1448);
    @(posedge clk); #1;
    check("str2_valid", 32'(out_valid), 1);
    check("str2_data", 32'(data_out), 65360);
    check("str2_sat", 32'(sat), 0);
    @(posedge clk); #1;
    check("str_end", 32'(out_valid), 0);
    // saturation
    drive(16'h1000);
    drive(16'hFF00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("sat0_data", 32'(data_out), 32'hFFFF);
    check("sat0_sat", 32'(sat), 1);
    @(posedge clk); #1;
    check("sat1_data", 32'(data_out), 32'hFFFF);
    check("sat1_sat", 32'(sat), 1);
    @(posedge clk); #1;
    // stall with 3 in flight and a 4th waiting at the input
    drive(16'h0500);
    drive(16'h0600);
    drive(16'h0700);
    out_ready = 1'b0;
    data_in = 16'h0800;
    n0 = nout;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_rdy", 32'(in_ready), 0);
      check("stall_vld", 32'(out_valid), 1);
      check("stall_data", 32'(data_out), 32);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rel0_data", 32'(data_out), 64);
    @(posedge clk); #1;
    check("rel1_data", 32'(data_out), 128);
    @(posedge clk); #1;
    check("rel2_data", 32'(data_out), 256);
    @(posedge clk); #1;
    check("rel_end", 32'(out_valid), 0);
    check("rel_count", 32'(nout - n0), 4);
    // reset mid-stream
    drive(16'h0300);
    drive(16'h0310);
    drive(16'h0320);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_data", 32'(data_out), 0);
    check("mrst_sat", 32'(sat), 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(16'h0200);
    in_valid = 1'b0;
    check("post_c1", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("post_c2", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("post_c3", 32'(out_valid), 1);
    check("post_data", 32'(data_out), 4);
    @(posedge clk); #1;
    // random traffic, input held while stalled
    acc = 0;
    sent = 1'b1;
    for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
      if (!in_valid || sent) begin
        in_valid = ($urandom_range(0, 3) != 0);
        data_in = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {8'($urandom_range(0, 17)), 8'($urandom)};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1 sent = in_valid && in_ready;
      if (sent) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && sb.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("rand_accept", 32'(acc), 10000);
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
